// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline flush/stall controller.
package pipe_flush_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_DRAIN  = 2'd2
   } pfc_state_e;

   localparam logic [15:0] EXC_VECTOR_DEF = 16'h0002;

   localparam int unsigned STAGE_IF          = 0;
   localparam int unsigned RESOLVE_STAGE_DEF = 2;
   localparam int unsigned STALL_STAGE_DEF   = 1;

   // Mask with bits 0..n-1 set; callers truncate to their stage count.
   function automatic logic [31:0] low_mask(input int unsigned n);
      if (n >= 32) return '1;
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/pfc_valid_shift.sv
// Per-stage valid shift register with squash, stall hold and bubble insertion.
module pfc_valid_shift
   import pipe_flush_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned STALL_STAGE = STALL_STAGE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_valid,
   input  logic                  fetch_hold,
   input  logic                  stall_hold,
   input  logic [NUM_STAGES-1:0] kill,
   output logic [NUM_STAGES-1:0] stage_valid
);

   logic [NUM_STAGES-1:0] valid_nxt;

   // A killed stage never passes its instruction on; a stall freezes the front and bubbles the next stage.
   always_comb begin
      valid_nxt           = '0;
      valid_nxt[STAGE_IF] = fetch_valid & ~fetch_hold & ~(|kill);
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
         valid_nxt[i] = stage_valid[i-1] & ~kill[i-1];
      end
      if (stall_hold) begin
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (i <= STALL_STAGE) valid_nxt[i] = stage_valid[i];
         end
         valid_nxt[STALL_STAGE+1] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stage_valid <= '0;
      else      stage_valid <= valid_nxt;
   end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Flush/stall controller: squashes younger stages, issues fetch redirects, inserts fetch bubbles.
module pipe_flush_ctrl
   import pipe_flush_ctrl_pkg::*;
#(
   parameter int unsigned     NUM_STAGES    = 4,
   parameter int unsigned     RESOLVE_STAGE = RESOLVE_STAGE_DEF,
   parameter int unsigned     STALL_STAGE   = STALL_STAGE_DEF,
   parameter int unsigned     REDIRECT_LAT  = 1,
   parameter int unsigned     PC_W          = 16,
   parameter logic [PC_W-1:0] EXC_VECTOR    = PC_W'(EXC_VECTOR_DEF),
   parameter int unsigned     CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_valid,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic                  jmp,
   input  logic [PC_W-1:0]       target_pc,
   input  logic                  exc_req,
   input  logic                  mem_idle,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [NUM_STAGES-1:0] kill,
   output logic                  branch_or_jmp,
   output logic                  redirect_valid,
   output logic [PC_W-1:0]       redirect_pc,
   output logic                  fetch_hold,
   output logic                  flush_busy,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int unsigned           BCNT_W   = (REDIRECT_LAT > 1) ? $clog2(REDIRECT_LAT) : 1;
   localparam logic [BCNT_W-1:0]     BCNT_RLD = BCNT_W'(REDIRECT_LAT - 1);
   localparam logic [NUM_STAGES-1:0] KILL_BR  = NUM_STAGES'(low_mask(RESOLVE_STAGE));
   localparam logic [NUM_STAGES-1:0] KILL_EXC = NUM_STAGES'(low_mask(NUM_STAGES - 1));

   pfc_state_e        state, state_nxt;
   logic [BCNT_W-1:0] bcnt, bcnt_nxt;
   logic              redir_nxt;
   logic [PC_W-1:0]   redir_pc_nxt;
   logic              exc_acc;
   logic              stall_hold;

   // While draining for an exception, later exceptions and branches are dropped.
   assign exc_acc       = exc_req & (state != ST_DRAIN);
   assign branch_or_jmp = (branch_taken | jmp) & stage_valid[RESOLVE_STAGE] & ~exc_acc
                          & (state != ST_DRAIN);
   assign kill          = exc_acc ? KILL_EXC : (branch_or_jmp ? KILL_BR : '0);
   assign stall_hold    = stall & ~(branch_or_jmp | exc_acc);

   pfc_valid_shift #(
      .NUM_STAGES  (NUM_STAGES),
      .STALL_STAGE (STALL_STAGE)
   ) u_valid_shift (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid),
      .fetch_hold  (fetch_hold),
      .stall_hold  (stall_hold),
      .kill        (kill),
      .stage_valid (stage_valid)
   );

   // Next-state logic; exceptions outrank branches, latest branch redirect wins.
   always_comb begin
      state_nxt    = state;
      bcnt_nxt     = bcnt;
      redir_nxt    = 1'b0;
      redir_pc_nxt = redirect_pc;
      case (state)
         ST_IDLE, ST_BUBBLE: begin
            if (exc_acc) begin
               state_nxt = ST_DRAIN;
            end else if (branch_or_jmp) begin
               state_nxt    = ST_BUBBLE;
               redir_nxt    = 1'b1;
               redir_pc_nxt = target_pc;
               bcnt_nxt     = BCNT_RLD;
            end else if (state == ST_BUBBLE) begin
               if (bcnt == '0) state_nxt = ST_IDLE;
               else            bcnt_nxt  = bcnt - BCNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (mem_idle) begin
               state_nxt    = ST_BUBBLE;
               redir_nxt    = 1'b1;
               redir_pc_nxt = EXC_VECTOR;
               bcnt_nxt     = BCNT_RLD;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         bcnt           <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         fetch_hold     <= 1'b0;
         flush_busy     <= 1'b0;
      end else begin
         state          <= state_nxt;
         bcnt           <= bcnt_nxt;
         redirect_valid <= redir_nxt;
         redirect_pc    <= redir_pc_nxt;
         fetch_hold     <= (state_nxt != ST_IDLE);
         flush_busy     <= (state_nxt != ST_IDLE);
      end
   end

   // Saturating count of accepted flushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_cnt <= '0;
      end else if ((branch_or_jmp | exc_acc) && (flush_cnt != '1)) begin
         flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl with a 2-bit flush counter to reach saturation.
module tb_pipe_flush_ctrl;

   localparam int unsigned NS    = 4;
   localparam int unsigned PC_W  = 16;
   localparam int unsigned CNT_W = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            fetch_valid, stall, branch_taken, jmp, exc_req, mem_idle;
   logic [PC_W-1:0] target_pc;
   logic [NS-1:0]   stage_valid, kill;
   logic            branch_or_jmp, redirect_valid, fetch_hold, flush_busy;
   logic [PC_W-1:0] redirect_pc;
   logic [CNT_W-1:0] flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_flush_ctrl #(
      .NUM_STAGES (NS),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_valid    (fetch_valid),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .jmp            (jmp),
      .target_pc      (target_pc),
      .exc_req        (exc_req),
      .mem_idle       (mem_idle),
      .stage_valid    (stage_valid),
      .kill           (kill),
      .branch_or_jmp  (branch_or_jmp),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_hold     (fetch_hold),
      .flush_busy     (flush_busy),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; fetch_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0; jmp = 1'b0;
      exc_req = 1'b0; mem_idle = 1'b1; target_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid",  32'(stage_valid), 32'h0);
      check_eq("rst_busy",   32'(flush_busy), 32'h0);
      check_eq("rst_hold",   32'(fetch_hold), 32'h0);
      check_eq("rst_redir",  32'(redirect_valid), 32'h0);
      check_eq("rst_cnt",    32'(flush_cnt), 32'h0);
      rst = 1'b1;

      // Fill, then taken branch
      fetch_valid = 1'b1;
      repeat (4) step();
      check_eq("fill_valid", 32'(stage_valid), 32'hF);
      branch_taken = 1'b1; target_pc = 16'h0040;
      #1;
      check_eq("br_kill", 32'(kill), 32'h3);
      check_eq("br_boj",  32'(branch_or_jmp), 32'h1);
      step();
      branch_taken = 1'b0;
      check_eq("br_redir_v",  32'(redirect_valid), 32'h1);
      check_eq("br_redir_pc", 32'(redirect_pc), 32'h0040);
      check_eq("br_valid",    32'(stage_valid), 32'h8);
      check_eq("br_hold",     32'(fetch_hold), 32'h1);
      check_eq("br_cnt",      32'(flush_cnt), 32'h1);
      step();
      check_eq("br_idle_redir", 32'(redirect_valid), 32'h0);
      check_eq("br_idle_hold",  32'(fetch_hold), 32'h0);
      check_eq("br_idle_busy",  32'(flush_busy), 32'h0);
      check_eq("br_bubble_v",   32'(stage_valid), 32'h0);
      step();
      check_eq("refetch_v", 32'(stage_valid), 32'h1);

      // Stall with full pipe
      repeat (3) step();
      check_eq("st_full", 32'(stage_valid), 32'hF);
      stall = 1'b1;
      #1;
      check_eq("st_kill", 32'(kill), 32'h0);
      step();
      check_eq("st_v1", 32'(stage_valid), 32'hB);
      step();
      check_eq("st_v2", 32'(stage_valid), 32'h3);
      stall = 1'b0;
      step();
      check_eq("st_res1", 32'(stage_valid), 32'h7);
      step();
      check_eq("st_res2", 32'(stage_valid), 32'hF);

      // Stall and jump together: flush wins
      stall = 1'b1; jmp = 1'b1; target_pc = 16'h0080;
      #1;
      check_eq("sj_kill", 32'(kill), 32'h3);
      check_eq("sj_boj",  32'(branch_or_jmp), 32'h1);
      step();
      stall = 1'b0; jmp = 1'b0;
      check_eq("sj_valid",    32'(stage_valid), 32'h8);
      check_eq("sj_redir_v",  32'(redirect_valid), 32'h1);
      check_eq("sj_redir_pc", 32'(redirect_pc), 32'h0080);
      check_eq("sj_cnt",      32'(flush_cnt), 32'h2);
      repeat (5) step();
      check_eq("sj_refill", 32'(stage_valid), 32'hF);

      // Exception with memory busy, then drain completes
      exc_req = 1'b1; mem_idle = 1'b0;
      #1;
      check_eq("ex_kill", 32'(kill), 32'h7);
      step();
      exc_req = 1'b0;
      check_eq("ex_valid", 32'(stage_valid), 32'h0);
      check_eq("ex_cnt",   32'(flush_cnt), 32'h3);
      for (int i = 0; i < 3; i++) begin
         check_eq("ex_drain_hold",  32'(fetch_hold), 32'h1);
         check_eq("ex_drain_busy",  32'(flush_busy), 32'h1);
         check_eq("ex_drain_redir", 32'(redirect_valid), 32'h0);
         if (i < 2) step();
      end
      mem_idle = 1'b1;
      step();
      check_eq("ex_redir_v",  32'(redirect_valid), 32'h1);
      check_eq("ex_redir_pc", 32'(redirect_pc), 32'h0002);
      check_eq("ex_bub_hold", 32'(fetch_hold), 32'h1);
      step();
      check_eq("ex_idle_redir", 32'(redirect_valid), 32'h0);
      check_eq("ex_idle_hold",  32'(fetch_hold), 32'h0);
      check_eq("ex_idle_busy",  32'(flush_busy), 32'h0);

      // Counter saturation and unqualified branch
      repeat (4) step();
      check_eq("sat_full", 32'(stage_valid), 32'hF);
      branch_taken = 1'b1; target_pc = 16'h0010;
      step();
      branch_taken = 1'b0;
      check_eq("sat_cnt4", 32'(flush_cnt), 32'h3);
      check_eq("sat_redir_pc", 32'(redirect_pc), 32'h0010);
      branch_taken = 1'b1;
      #1;
      check_eq("nq_kill", 32'(kill), 32'h0);
      check_eq("nq_boj",  32'(branch_or_jmp), 32'h0);
      step();
      branch_taken = 1'b0;
      check_eq("nq_redir", 32'(redirect_valid), 32'h0);
      check_eq("nq_cnt",   32'(flush_cnt), 32'h3);
      repeat (4) step();
      jmp = 1'b1; target_pc = 16'h0020;
      step();
      jmp = 1'b0;
      check_eq("sat_redir5", 32'(redirect_valid), 32'h1);
      check_eq("sat_cnt5",   32'(flush_cnt), 32'h3);

      // Asynchronous reset while in BUBBLE
      check_eq("mb_busy_pre", 32'(flush_busy), 32'h1);
      rst = 1'b0;
      #1;
      check_eq("mb_valid", 32'(stage_valid), 32'h0);
      check_eq("mb_busy",  32'(flush_busy), 32'h0);
      check_eq("mb_cnt",   32'(flush_cnt), 32'h0);
      check_eq("mb_redir", 32'(redirect_valid), 32'h0);
      check_eq("mb_hold",  32'(fetch_hold), 32'h0);
      step();
      rst = 1'b1;
      step();
      check_eq("post_rst_v", 32'(stage_valid), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
